// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file with busy scoreboard.
package regfile_pkg;
  localparam int DW_DEFAULT   = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int NRD_DEFAULT  = 2;
  localparam int REG_ZERO     = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode-stage register file bus: write/clear, scoreboard set, NRD read ports.
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = NRD_DEFAULT
);
  localparam int AW = $clog2(NREG);

  logic              wena;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              wclr;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              bset;
  logic [AW-1:0]     baddr;
  logic              busy_any;

  modport master (output wena, waddr, wdata, wclr, raddr, bset, baddr,
                  input  rdata, rbusy, busy_any);
  modport slave  (input  wena, waddr, wdata, wclr, raddr, bset, baddr,
                  output rdata, rbusy, busy_any);
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on multicycle issue, cleared by final writeback, set wins.
// REGFILE_BYPASS_EN: a same-cycle clear hides the busy bit on the matching read port.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = NRD_DEFAULT,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [AW-1:0]     saddr_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     caddr_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD-1:0]    rbusy_o,
  output logic              busy_any_o
);
  logic [NREG-1:0] busy_q, busy_d;

  // Clear applied first so a same-address set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_i && caddr_i != AW'(REG_ZERO)) busy_d[caddr_i] = 1'b0;
    if (set_i && saddr_i != AW'(REG_ZERO)) busy_d[saddr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rbusy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      rbusy_o[i] = busy_q[raddr_i[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (clr_i && caddr_i == raddr_i[i*AW +: AW]) rbusy_o[i] = 1'b0;
`endif
    end
  end

  assign busy_any_o = |busy_q;
endmodule

// File: rtl/regfile_sb.sv
// Register file, r0 hard-wired to zero, combinational reads, busy scoreboard.
// REGFILE_BYPASS_EN: forwards same-cycle write data to matching read ports.
module regfile_sb import regfile_pkg::*; #(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = NRD_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [DW-1:0]     mem_q [NREG];
  logic [NRD*DW-1:0] rdata_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (bus.wena && bus.waddr != AW'(REG_ZERO)) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < NRD; i++) begin
      if (bus.raddr[i*AW +: AW] != AW'(REG_ZERO))
        rdata_c[i*DW +: DW] = mem_q[bus.raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed during reset so reads stay zero.
      if (!rst && bus.wena && bus.waddr != AW'(REG_ZERO) &&
          bus.waddr == bus.raddr[i*AW +: AW])
        rdata_c[i*DW +: DW] = bus.wdata;
`endif
    end
  end

  assign bus.rdata = rdata_c;

  regfile_scoreboard #(.NREG(NREG), .NRD(NRD), .AW(AW)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (bus.bset),
    .saddr_i    (bus.baddr),
    .clr_i      (bus.wena & bus.wclr),
    .caddr_i    (bus.waddr),
    .raddr_i    (bus.raddr),
    .rbusy_o    (bus.rbusy),
    .busy_any_o (bus.busy_any)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, hand-written corner sequences, random vs. model.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  regfile_sb_if #(.DW(32), .NREG(32), .NRD(2)) bus ();
  regfile_sb #(.DW(32), .NREG(32), .NRD(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wclr;
    logic        bset;
    logic [4:0]  baddr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erb;
    logic        eany;
  } vec_t;

  vec_t tbl[11];

  logic [31:0] m_mem [32];
  logic        m_busy[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wena = 1'b0; bus.wclr = 1'b0; bus.bset = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] exp_rd;
    logic        exp_rb;
    logic        exp_any;

    rst = 1'b1;
    bus.wena = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wclr = 1'b0;
    bus.raddr = '0; bus.bset = 1'b0; bus.baddr = '0;

    // Writes attempted while reset is held must not appear.
    #3;
    bus.wena = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hFFFF_0000; bus.raddr = {5'd5, 5'd5};
    #14;
    check("in_reset_rdata0", bus.rdata[31:0], 32'h0);
    check("in_reset_rdata1", bus.rdata[63:32], 32'h0);
    check("in_reset_busy_any", {31'b0, bus.busy_any}, 32'h0);
    idle_inputs();
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.raddr = {5'(31 - i), 5'(i)};
      #2;
      check("reset_rdata0", bus.rdata[31:0], 32'h0);
      check("reset_rdata1", bus.rdata[63:32], 32'h0);
      check("reset_rbusy", {30'b0, bus.rbusy}, 32'h0);
      check("reset_busy_any", {31'b0, bus.busy_any}, 32'h0);
    end

    //              wena waddr  wdata          wclr bset baddr ra0   ra1   e0             e1             erb    eany
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0};
    tbl[1]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd9, 5'd9, 5'd5, 32'h0,        32'hDEADBEEF, 2'b01, 1'b1};
    tbl[3]  = '{1'b1, 5'd9, 32'h55,       1'b1, 1'b0, 5'd0, 5'd9, 5'd9, 32'h55,       32'h55,       2'b00, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 5'd3, 5'd4, 32'h0,        32'h0,        2'b01, 1'b1};
    tbl[5]  = '{1'b1, 5'd3, 32'h77,       1'b1, 1'b1, 5'd3, 5'd3, 5'd4, 32'h77,       32'h0,        2'b01, 1'b1};
    tbl[6]  = '{1'b1, 5'd3, 32'h88,       1'b1, 1'b1, 5'd4, 5'd3, 5'd4, 32'h88,       32'h0,        2'b10, 1'b1};
    tbl[7]  = '{1'b1, 5'd4, 32'h11,       1'b0, 1'b0, 5'd0, 5'd4, 5'd3, 32'h11,       32'h88,       2'b01, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 32'h11,       32'h0,        2'b01, 1'b1};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'h0,        32'h11,       2'b10, 1'b1};
    tbl[10] = '{1'b1, 5'd4, 32'h22,       1'b1, 1'b0, 5'd0, 5'd4, 5'd3, 32'h22,       32'h88,       2'b00, 1'b0};

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      bus.wena = tbl[k].wena; bus.waddr = tbl[k].waddr; bus.wdata = tbl[k].wdata;
      bus.wclr = tbl[k].wclr; bus.bset = tbl[k].bset; bus.baddr = tbl[k].baddr;
      bus.raddr = {tbl[k].ra1, tbl[k].ra0};
      @(posedge clk);
      #1 idle_inputs();
      #1;
      check($sformatf("vec%0d_rdata0", k), bus.rdata[31:0], tbl[k].e0);
      check($sformatf("vec%0d_rdata1", k), bus.rdata[63:32], tbl[k].e1);
      check($sformatf("vec%0d_rbusy", k), {30'b0, bus.rbusy}, {30'b0, tbl[k].erb});
      check($sformatf("vec%0d_busy_any", k), {31'b0, bus.busy_any}, {31'b0, tbl[k].eany});
    end

    // Same-cycle read of the register being written (r7 never written before).
    @(negedge clk);
    bus.wena = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA5A5A5A5; bus.raddr = {5'd7, 5'd0};
    #2;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", bus.rdata[63:32], 32'hA5A5A5A5);
`else
    check("no_bypass_same_cycle", bus.rdata[63:32], 32'h0);
`endif
    @(posedge clk);
    #1 idle_inputs();
    #1 check("bypass_after_edge", bus.rdata[63:32], 32'hA5A5A5A5);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    bus.wena = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'hCAFE; bus.bset = 1'b1; bus.baddr = 5'd10;
    bus.raddr = {5'd7, 5'd10};
    @(posedge clk);
    #1 idle_inputs();
    #1;
    check("pre_rst_r10", bus.rdata[31:0], 32'hCAFE);
    check("pre_rst_rbusy", {30'b0, bus.rbusy}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_r10", bus.rdata[31:0], 32'h0);
    check("async_rst_r7", bus.rdata[63:32], 32'h0);
    check("async_rst_rbusy", {30'b0, bus.rbusy}, 32'h0);
    check("async_rst_busy_any", {31'b0, bus.busy_any}, 32'h0);
    @(negedge clk) rst = 1'b0;
    model_clear();

    // Random traffic on a narrow address window to force collisions.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      bus.wena  = 1'($urandom_range(0, 1));
      bus.waddr = 5'($urandom_range(0, 7));
      bus.wdata = $urandom;
      bus.wclr  = 1'($urandom_range(0, 1));
      bus.bset  = 1'($urandom_range(0, 2) == 0);
      bus.baddr = 5'($urandom_range(0, 7));
      bus.raddr = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      #2;
      exp_any = 1'b0;
      for (int r = 0; r < 32; r++) exp_any = exp_any | m_busy[r];
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? bus.raddr[4:0] : bus.raddr[9:5];
        exp_rd = (a == 0) ? 32'h0 : m_mem[a];
        exp_rb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.wena && bus.waddr != 0 && bus.waddr == a) exp_rd = bus.wdata;
        if (bus.wena && bus.wclr && bus.waddr == a) exp_rb = 1'b0;
`endif
        check($sformatf("rand%0d_rdata%0d", n, p), (p == 0) ? bus.rdata[31:0] : bus.rdata[63:32], exp_rd);
        check($sformatf("rand%0d_rbusy%0d", n, p), {31'b0, bus.rbusy[p]}, {31'b0, exp_rb});
      end
      check($sformatf("rand%0d_busy_any", n), {31'b0, bus.busy_any}, {31'b0, exp_any});
      @(posedge clk);
      if (bus.wena && bus.waddr != 0) begin
        m_mem[bus.waddr] = bus.wdata;
        if (bus.wclr) m_busy[bus.waddr] = 1'b0;
      end
      if (bus.bset && bus.baddr != 0) m_busy[bus.baddr] = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
